// File: rtl/registers_bank_mp_pkg.sv
// ============================================================================
// Module : registers_bank_mp_pkg
// Brief  : Shared types and constants for the multi-port register bank.
//          Optional feature macro used by this slice: REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CLEAR
`define CLEAR(width) {(width){1'b0}}
`endif

package registers_bank_mp_pkg;

  localparam int DEFAULT_READ_PORTS = 2;

  typedef enum logic [0:0] {
    RB_STATE_IDLE  = 1'b0,
    RB_STATE_CLEAR = 1'b1
  } rb_state_e;

endpackage

`default_nettype wire

// File: rtl/registers_bank_read_port.sv
// ============================================================================
// Module : registers_bank_read_port
// Brief  : One asynchronous read port. Masks to zero while the bank is being
//          cleared. Write-through forwarding when REGFILE_BYPASS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registers_bank_read_port #(
  parameter int BANK_SIZE = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 1
) (
  input  logic [BANK_SIZE*DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic                        busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                        wr_accept_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic [DATA_W-1:0]           wr_data_i,
`endif
  output logic [DATA_W-1:0]           data_o
);

  always_comb begin
    data_o = regs_i[int'(addr_i)*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
    if (wr_accept_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
`endif
    if ((ZERO_REG != 0) && (addr_i == '0)) begin
      data_o = '0;
    end
    // The ID stage stalls on busy, so partially cleared contents are hidden.
    if (busy_i) begin
      data_o = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/registers_bank_mp.sv
// ============================================================================
// Module : registers_bank_mp
// Brief  : ID-stage register file, N read ports, one write port, sequential
//          one-entry-per-cycle flush. Optional macro: REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registers_bank_mp
  import registers_bank_mp_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE      = 32,
  parameter int READ_PORTS          = DEFAULT_READ_PORTS,
  parameter int ZERO_REG            = 1,
  localparam int ADDR_W             = $clog2(REGISTERS_BANK_SIZE)
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset_n,
  input  logic                                       i_flush,
  input  logic                                       i_write_enable,
  input  logic [ADDR_W-1:0]                          i_addr_wr,
  input  logic [REGISTERS_SIZE-1:0]                  i_bus_wr,
  input  logic [READ_PORTS*ADDR_W-1:0]               i_addr_rd,
  output logic [READ_PORTS*REGISTERS_SIZE-1:0]       o_bus_rd,
  output logic                                       o_busy,
  output logic                                       o_wr_drop,
  output logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] o_bus_debug
);

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(REGISTERS_BANK_SIZE - 1);

  rb_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      wr_drop_q, wr_drop_d;
  logic [REGISTERS_SIZE-1:0] regs_q [REGISTERS_BANK_SIZE];

  logic                      w_clr_en;
  logic [ADDR_W-1:0]         w_clr_idx;
  logic                      w_wr_accept;

  assign w_wr_accept = i_write_enable && !i_flush && (state_q == RB_STATE_IDLE) &&
                       !((ZERO_REG != 0) && (i_addr_wr == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_clr_en  = 1'b0;
    w_clr_idx = '0;
    // A flush in either state (re)starts the sweep at entry 0.
    if (i_flush) begin
      state_d  = RB_STATE_CLEAR;
      cnt_d    = ADDR_W'(1);
      w_clr_en = 1'b1;
    end else if (state_q == RB_STATE_CLEAR) begin
      w_clr_en  = 1'b1;
      w_clr_idx = cnt_q;
      cnt_d     = cnt_q + ADDR_W'(1);
      if (cnt_q == C_LAST_IDX) begin
        state_d = RB_STATE_IDLE;
      end
    end
    // Busy covers the cycle after each clearing edge, including the last one.
    busy_d    = i_flush || (state_q == RB_STATE_CLEAR);
    wr_drop_d = i_write_enable && (i_flush || (state_q == RB_STATE_CLEAR));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= RB_STATE_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
        regs_q[i] <= `CLEAR(REGISTERS_SIZE);
      end
    end else if (w_clr_en) begin
      regs_q[w_clr_idx] <= `CLEAR(REGISTERS_SIZE);
    end else if (w_wr_accept) begin
      regs_q[i_addr_wr] <= i_bus_wr;
    end
  end

  assign o_busy    = busy_q;
  assign o_wr_drop = wr_drop_q;

  generate
    for (genvar j = 0; j < REGISTERS_BANK_SIZE; j++) begin : g_debug
      assign o_bus_debug[j*REGISTERS_SIZE +: REGISTERS_SIZE] = regs_q[j];
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_read_port
      registers_bank_read_port #(
        .BANK_SIZE (REGISTERS_BANK_SIZE),
        .DATA_W    (REGISTERS_SIZE),
        .ADDR_W    (ADDR_W),
        .ZERO_REG  (ZERO_REG)
      ) u_read_port (
        .regs_i      (o_bus_debug),
        .addr_i      (i_addr_rd[k*ADDR_W +: ADDR_W]),
        .busy_i      (busy_q),
`ifdef REGFILE_BYPASS_EN
        .wr_accept_i (w_wr_accept),
        .wr_addr_i   (i_addr_wr),
        .wr_data_i   (i_bus_wr),
`endif
        .data_o      (o_bus_rd[k*REGISTERS_SIZE +: REGISTERS_SIZE])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_registers_bank_mp.sv
// ============================================================================
// Module : tb_registers_bank_mp
// Brief  : Self-checking bench for registers_bank_mp (3 read ports, 32x32).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_registers_bank_mp;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int RP = 3;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             we = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [W-1:0]     wdata = '0;
  logic [RP*AW-1:0] raddr = '0;
  logic [RP*W-1:0]  rdata;
  logic             busy;
  logic             drop;
  logic [N*W-1:0]   dbg;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE (N),
    .REGISTERS_SIZE      (W),
    .READ_PORTS          (RP),
    .ZERO_REG            (1)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_flush        (flush),
    .i_write_enable (we),
    .i_addr_wr      (waddr),
    .i_bus_wr       (wdata),
    .i_addr_rd      (raddr),
    .o_bus_rd       (rdata),
    .o_busy         (busy),
    .o_wr_drop      (drop),
    .o_bus_debug    (dbg)
  );

  // Reference model: architectural contents plus progress of an ongoing clear.
  logic [W-1:0] mem [N];
  int           clr_next  = -1;
  int           busy_left = 0;
  bit           drop_exp  = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem[i] = '0;
    clr_next  = -1;
    busy_left = 0;
    drop_exp  = 1'b0;
  endtask

  task automatic model_edge();
    bit clearing;
    bit acc;
    clearing = (clr_next >= 0);
    acc      = we && !flush && !clearing && (waddr != 0);
    drop_exp = we && (flush || clearing);
    if (flush) begin
      mem[0]    = '0;
      clr_next  = 1;
      busy_left = N;
    end else begin
      if (busy_left > 0) busy_left--;
      if (clearing) begin
        mem[clr_next] = '0;
        clr_next = (clr_next == N - 1) ? -1 : clr_next + 1;
      end else if (acc) begin
        mem[waddr] = wdata;
      end
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (busy_left > 0) return '0;
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !flush && (clr_next < 0) && (waddr == a)) return wdata;
`endif
    return mem[a];
  endfunction

  function automatic logic [N*W-1:0] exp_dbg();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = mem[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++;
    if (drop !== 1'b0) $display("FAIL reset_drop: got %b want 0", drop); else passed++;
    total++;
    if (dbg !== '0) $display("FAIL reset_debug: debug bus not all zero"); else passed++;
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_write_basic();
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    raddr[0 +: AW] = 5;
    #1;
    total++;
    if (rdata[0 +: W] !== 32'hDEADBEEF)
      $display("FAIL write_r5_read: got %h want deadbeef", rdata[0 +: W]); else passed++;
    total++;
    if (dbg[5*W +: W] !== 32'hDEADBEEF)
      $display("FAIL write_r5_debug: got %h want deadbeef", dbg[5*W +: W]); else passed++;
    we = 1'b1; waddr = 0; wdata = 32'h1234;
    tick();
    we = 1'b0;
    raddr[0 +: AW] = 0;
    #1;
    total++;
    if (rdata[0 +: W] !== '0) $display("FAIL zero_reg_read: got %h want 0", rdata[0 +: W]); else passed++;
    total++;
    if (drop !== 1'b0) $display("FAIL zero_reg_drop: got %b want 0", drop); else passed++;
    total++;
    if (dbg[0 +: W] !== '0) $display("FAIL zero_reg_debug: got %h want 0", dbg[0 +: W]); else passed++;
  endtask

  task automatic test_multiport();
    for (int i = 1; i <= 3; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = W'(i);
      tick();
    end
    we = 1'b0;
    raddr = {5'd1, 5'd1, 5'd3};
    #1;
    total++;
    if (rdata !== {32'd1, 32'd1, 32'd3})
      $display("FAIL multiport: got %h want %h", rdata, {32'd1, 32'd1, 32'd3}); else passed++;
  endtask

  task automatic test_flush_timing();
    int cnt;
    bit bad;
    for (int i = 1; i < N; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = $urandom() | 32'h1;
      tick();
    end
    we = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cnt = 0;
    bad = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      for (int k = 0; k < RP; k++) raddr[k*AW +: AW] = AW'($urandom_range(1, N - 1));
      #1;
      if (rdata !== '0) bad = 1'b1;
      tick();
    end
    total++;
    if (cnt != N) $display("FAIL flush_busy_len: got %0d want %0d", cnt, N); else passed++;
    total++;
    if (bad) $display("FAIL flush_read_mask: got nonzero read want 0 while busy"); else passed++;
    total++;
    if (dbg !== '0) $display("FAIL flush_debug_clear: debug bus not all zero"); else passed++;
  endtask

  task automatic test_write_during_clear();
    int cnt;
    we = 1'b1; waddr = 7; wdata = 32'h7777_0007;
    tick();
    we = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      total++;
      if (busy !== 1'b1) $display("FAIL clear_busy_c%0d: got %b want 1", cyc, busy); else passed++;
      if (cyc == 10) begin we = 1'b1; waddr = 7; wdata = $urandom(); end
      if (cyc == 11) begin
        we = 1'b0;
        total++;
        if (drop !== 1'b1) $display("FAIL clear_wr_drop: got %b want 1", drop); else passed++;
      end
      if (cyc == 12) begin
        total++;
        if (drop !== 1'b0) $display("FAIL clear_wr_drop_end: got %b want 0", drop); else passed++;
      end
      if (cyc == 20) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    total++;
    if (cnt != N) $display("FAIL restart_busy_len: got %0d want %0d", cnt, N); else passed++;
    total++;
    if (dbg[7*W +: W] !== '0) $display("FAIL clear_r7: got %h want 0", dbg[7*W +: W]); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 6; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = $urandom() | 32'h1;
      tick();
    end
    we = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    we = 1'b1; waddr = 3; wdata = 32'h3;
    tick();
    we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", busy); else passed++;
    total++;
    if (drop !== 1'b0) $display("FAIL async_rst_drop: got %b want 0", drop); else passed++;
    total++;
    if (dbg !== '0) $display("FAIL async_rst_debug: debug bus not all zero"); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 9; wdata = 32'h1111_1111;
    tick();
    we = 1'b1; waddr = 9; wdata = 32'hA5A5A5A5;
    raddr[1*AW +: AW] = 9;
    #1;
    total++;
`ifdef REGFILE_BYPASS_EN
    if (rdata[1*W +: W] !== 32'hA5A5A5A5)
      $display("FAIL bypass_same_cycle: got %h want a5a5a5a5", rdata[1*W +: W]); else passed++;
`else
    if (rdata[1*W +: W] !== 32'h1111_1111)
      $display("FAIL bypass_same_cycle: got %h want 11111111", rdata[1*W +: W]); else passed++;
`endif
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata[1*W +: W] !== 32'hA5A5A5A5)
      $display("FAIL bypass_next_cycle: got %h want a5a5a5a5", rdata[1*W +: W]); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 59) == 0);
      we    = $urandom_range(0, 1) == 1;
      waddr = AW'($urandom_range(0, N - 1));
      wdata = $urandom();
      for (int k = 0; k < RP; k++)
        raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, N - 1));
      #1;
      for (int k = 0; k < RP; k++) begin
        total++;
        if (rdata[k*W +: W] !== exp_rd(raddr[k*AW +: AW])) begin
          if (errs < 10) $display("FAIL rand_read c%0d p%0d: got %h want %h",
                                  c, k, rdata[k*W +: W], exp_rd(raddr[k*AW +: AW]));
          errs++;
        end else passed++;
      end
      total++;
      if (busy !== (busy_left > 0) || drop !== drop_exp) begin
        if (errs < 10) $display("FAIL rand_flags c%0d: got busy=%b drop=%b want busy=%b drop=%b",
                                c, busy, drop, busy_left > 0, drop_exp);
        errs++;
      end else passed++;
      total++;
      if (dbg !== exp_dbg()) begin
        if (errs < 10) $display("FAIL rand_debug c%0d: debug bus differs from model", c);
        errs++;
      end else passed++;
      tick();
    end
    flush = 1'b0;
    we    = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_basic();
    test_multiport();
    test_flush_timing();
    test_write_during_clear();
    test_async_reset();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule

`default_nettype wire
